// File: rtl/dual_chan_edge_counter_pkg.sv
// Shared types and defaults for the dual-channel edge counter.
// Holds the readout FSM encoding and the default counter and synchronizer sizes.
package dual_chan_edge_counter_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } rd_state_t;

endpackage

// File: rtl/dual_chan_edge_counter_if.sv
// Readout handshake bundle: request/ready from the consumer, beat payload back.
// The master side is the counter block that produces the beats.
interface dual_chan_edge_counter_if
    import dual_chan_edge_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             rd_req;
    logic             rd_ready;
    logic             rd_valid;
    logic             rd_chan;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             busy;

    modport master (
        input  rd_req,
        input  rd_ready,
        output rd_valid,
        output rd_chan,
        output rd_data,
        output rd_ovf,
        output busy
    );

    modport slave (
        output rd_req,
        output rd_ready,
        input  rd_valid,
        input  rd_chan,
        input  rd_data,
        input  rd_ovf,
        input  busy
    );

endinterface

// File: rtl/dual_chan_edge_counter_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous line plus a one-cycle rising-edge pulse.
// History clears to 0, so a line held high through reset yields one pulse afterwards.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/dual_chan_edge_counter.sv
// Counts rising edges on two asynchronous channel lines with sticky saturation flags,
// and returns a snapshot of both channels as two valid/ready beats (channel 0 first).
module dual_chan_edge_counter
    import dual_chan_edge_counter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ch0_in,
    input  logic                    ch1_in,
    input  logic                    clr,
    dual_chan_edge_counter_if.master rd
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rd_state_t          state_reg;
    rd_state_t          state_next;
    logic               snap_take;
    logic [1:0]         ch_line;
    wire  [1:0]         rise;
    wire  [2*CNT_W-1:0] snap_data;
    wire  [1:0]         snap_ovf;
    logic [CNT_W-1:0]   beat_data;
    logic               beat_ovf;

    assign ch_line = {ch1_in, ch0_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_upd;
            logic [CNT_W-1:0] snap_reg;
            logic             ovf_reg;
            logic             ovf_upd;
            logic             snap_ovf_reg;

            sync_edge_det #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (ch_line[gi]),
                .rise (rise[gi])
            );

            // Post-update view of the counter; the snapshot captures this so a
            // rise coincident with the request is not lost.
            always_comb begin
                cnt_upd = cnt_reg;
                ovf_upd = ovf_reg;
                if (rise[gi]) begin
                    if (cnt_reg == CNT_MAX) begin
                        ovf_upd = 1'b1;
                    end else begin
                        cnt_upd = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg      <= '0;
                    ovf_reg      <= 1'b0;
                    snap_reg     <= '0;
                    snap_ovf_reg <= 1'b0;
                end else begin
                    if (snap_take || clr) begin
                        cnt_reg <= '0;
                        ovf_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_upd;
                        ovf_reg <= ovf_upd;
                    end
                    if (snap_take) begin
                        snap_reg     <= cnt_upd;
                        snap_ovf_reg <= ovf_upd;
                    end
                end
            end

            assign snap_data[gi*CNT_W +: CNT_W] = snap_reg;
            assign snap_ovf[gi]                 = snap_ovf_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        snap_take  = 1'b0;
        beat_data  = '0;
        beat_ovf   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (rd.rd_req) begin
                    snap_take  = 1'b1;
                    state_next = SEND0;
                end
            end
            SEND0: begin
                beat_data = snap_data[0 +: CNT_W];
                beat_ovf  = snap_ovf[0];
                if (rd.rd_ready) begin
                    state_next = SEND1;
                end
            end
            SEND1: begin
                beat_data = snap_data[CNT_W +: CNT_W];
                beat_ovf  = snap_ovf[1];
                if (rd.rd_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat outputs decode only the state and snapshot registers, so they hold
    // steady across a stall.
    assign rd.busy     = (state_reg == SEND0) || (state_reg == SEND1);
    assign rd.rd_valid = (state_reg == SEND0) || (state_reg == SEND1);
    assign rd.rd_chan  = (state_reg == SEND1);
    assign rd.rd_data  = beat_data;
    assign rd.rd_ovf   = beat_ovf;

endmodule

// File: tb/tb_dual_chan_edge_counter.sv
// Drives an 8-bit and a 4-bit counter instance with the same stimulus and compares
// both against an event-level reference model every cycle.
module tb_dual_chan_edge_counter;

    localparam int S   = 2;
    localparam int W_A = 8;
    localparam int W_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ch0;
    logic ch1;
    logic clr;
    logic rd_req;
    logic rd_ready;

    dual_chan_edge_counter_if #(.CNT_W(W_A)) bus_a ();
    dual_chan_edge_counter_if #(.CNT_W(W_B)) bus_b ();

    assign bus_a.rd_req   = rd_req;
    assign bus_a.rd_ready = rd_ready;
    assign bus_b.rd_req   = rd_req;
    assign bus_b.rd_ready = rd_ready;

    dual_chan_edge_counter #(.CNT_W(W_A), .SYNC_STAGES(S)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ch0_in(ch0),
        .ch1_in(ch1),
        .clr   (clr),
        .rd    (bus_a)
    );

    dual_chan_edge_counter #(.CNT_W(W_B), .SYNC_STAGES(S)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ch0_in(ch0),
        .ch1_in(ch1),
        .clr   (clr),
        .rd    (bus_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index [w][c]: w=0 is the 8-bit instance, w=1 the 4-bit one; c is the channel.
    int cnt      [2][2];
    bit ovf      [2][2];
    int snap     [2][2];
    bit snap_ovf [2][2];
    int phase;            // 0 idle, 1 beat for channel 0 pending, 2 beat for channel 1 pending
    bit last_rst;
    bit samp [2][S+2];    // samp[c][k] = line value sampled k edges ago

    function automatic int max_of(input int w);
        return (w == 0) ? (1 << W_A) - 1 : (1 << W_B) - 1;
    endfunction

    always @(posedge clk) begin
        bit rise [2];
        bit line [2];
        line[0] = ch0;
        line[1] = ch1;
        if (!rst_n) begin
            phase    = 0;
            last_rst = 1'b1;
            for (int w = 0; w < 2; w++) begin
                for (int c = 0; c < 2; c++) begin
                    cnt[w][c]      = 0;
                    ovf[w][c]      = 1'b0;
                    snap[w][c]     = 0;
                    snap_ovf[w][c] = 1'b0;
                end
            end
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < S + 2; k++) samp[c][k] = 1'b0;
            end
        end else begin
            last_rst = 1'b0;
            // An edge counts S edges after the sample that first shows the line high.
            for (int c = 0; c < 2; c++) begin
                for (int k = S + 1; k > 0; k--) samp[c][k] = samp[c][k-1];
                samp[c][0] = line[c];
                rise[c]    = samp[c][S] && !samp[c][S+1];
            end
            for (int w = 0; w < 2; w++) begin
                for (int c = 0; c < 2; c++) begin
                    int nc;
                    bit no;
                    nc = cnt[w][c];
                    no = ovf[w][c];
                    if (rise[c]) begin
                        if (nc == max_of(w)) no = 1'b1;
                        else nc = nc + 1;
                    end
                    if (phase == 0 && rd_req) begin
                        snap[w][c]     = nc;
                        snap_ovf[w][c] = no;
                        cnt[w][c]      = 0;
                        ovf[w][c]      = 1'b0;
                    end else if (clr) begin
                        cnt[w][c] = 0;
                        ovf[w][c] = 1'b0;
                    end else begin
                        cnt[w][c] = nc;
                        ovf[w][c] = no;
                    end
                end
            end
            if (phase == 1 && rd_ready) begin
                $display("beat chan=0 cnt8=%0d ovf8=%0d cnt4=%0d ovf4=%0d",
                         snap[0][0], snap_ovf[0][0], snap[1][0], snap_ovf[1][0]);
                phase = 2;
            end else if (phase == 2 && rd_ready) begin
                $display("beat chan=1 cnt8=%0d ovf8=%0d cnt4=%0d ovf4=%0d",
                         snap[0][1], snap_ovf[0][1], snap[1][1], snap_ovf[1][1]);
                phase = 0;
            end else if (phase == 0 && rd_req) begin
                phase = 1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        int ec;
        ec = (phase == 2) ? 1 : 0;
        check("a_valid", 32'(bus_a.rd_valid), 32'(phase != 0));
        check("a_busy",  32'(bus_a.busy),     32'(phase != 0));
        check("b_valid", 32'(bus_b.rd_valid), 32'(phase != 0));
        check("b_busy",  32'(bus_b.busy),     32'(phase != 0));
        if (last_rst) begin
            check("a_rst_chan", 32'(bus_a.rd_chan), 32'd0);
            check("a_rst_data", 32'(bus_a.rd_data), 32'd0);
            check("a_rst_ovf",  32'(bus_a.rd_ovf),  32'd0);
            check("b_rst_data", 32'(bus_b.rd_data), 32'd0);
        end
        if (phase != 0) begin
            check("a_chan", 32'(bus_a.rd_chan), 32'(ec));
            check("a_data", 32'(bus_a.rd_data), 32'(snap[0][ec]));
            check("a_ovf",  32'(bus_a.rd_ovf),  32'(snap_ovf[0][ec]));
            check("b_chan", 32'(bus_b.rd_chan), 32'(ec));
            check("b_data", 32'(bus_b.rd_data), 32'(snap[1][ec]));
            check("b_ovf",  32'(bus_b.rd_ovf),  32'(snap_ovf[1][ec]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            if (c == 0) ch0 = 1'b1; else ch1 = 1'b1;
            tick(2);
            if (c == 0) ch0 = 1'b0; else ch1 = 1'b0;
            tick(2);
        end
    endtask

    task automatic readout();
        rd_req   = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_n    = 1'b0;
        ch0      = 1'b0;
        ch1      = 1'b0;
        clr      = 1'b0;
        rd_req   = 1'b0;
        rd_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Request lands on the exact edge the first rise becomes countable.
        ch0 = 1'b1;
        tick(2);
        rd_req   = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        ch0    = 1'b0;
        tick(4);

        // Request one edge too early: this rise must go to the next readout.
        ch0 = 1'b1;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        ch0    = 1'b0;
        tick(4);
        readout();

        pulse(0, 5);
        pulse(1, 2);
        tick(4);
        readout();

        pulse(1, 17);
        tick(4);
        readout();
        readout();

        // Stalled readout with a stray request in the middle of the stall.
        pulse(0, 2);
        tick(4);
        rd_ready = 1'b0;
        rd_req   = 1'b1;
        tick();
        rd_req = 1'b0;
        tick(2);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        rd_ready = 1'b1;
        tick(3);

        // Clear coincident with the request.
        pulse(0, 3);
        tick(4);
        clr    = 1'b1;
        rd_req = 1'b1;
        tick();
        clr    = 1'b0;
        rd_req = 1'b0;
        tick(3);
        readout();

        // Reset while the channel 1 beat is showing.
        pulse(1, 2);
        tick(4);
        rd_req   = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_req   = 1'b0;
        rd_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(3);
        readout();

        // Random traffic: frequent, then sparse readouts so both widths saturate.
        for (int i = 0; i < 5500; i++) begin
            int req_div;
            req_div = (i >= 1500 && i < 3500) ? 900 : 15;
            if ($urandom_range(2) == 0) ch0 = ~ch0;
            if ($urandom_range(3) == 0) ch1 = ~ch1;
            clr      = (req_div == 15) && ($urandom_range(40) == 0);
            rd_req   = ($urandom_range(req_div) == 0);
            rd_ready = ($urandom_range(1) == 0);
            rst_n    = ($urandom_range(800) != 0);
            tick();
        end
        rst_n    = 1'b1;
        clr      = 1'b0;
        rd_req   = 1'b0;
        rd_ready = 1'b1;
        tick(4);
        readout();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
